// File: rtl/myproject_mul_share_pkg.sv
// Shared constants, helper function and stage type for the shared-multiplier arbiter.
package myproject_mul_share_pkg;

   localparam int MUL_NUM_REQ = 4;
   localparam int MUL_A_WIDTH = 12;
   localparam int MUL_B_WIDTH = 16;
   localparam int MUL_P_WIDTH = 26;
   localparam int MUL_LAT     = 2;

   // Width of a requester tag; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int MUL_ID_W = id_width(MUL_NUM_REQ);

   // Operand capture stage: one accepted operation tagged with its owner.
   typedef struct packed {
      logic                          valid;
      logic [MUL_ID_W-1:0]           id;
      logic signed [MUL_A_WIDTH-1:0] a;
      logic signed [MUL_B_WIDTH-1:0] b;
   } mul_stage_t;

endpackage

// File: rtl/myproject_mul_share_rr.sv
// Round-robin grant: search begins just after the last granted requester.
module myproject_mul_share_rr
   import myproject_mul_share_pkg::*;
#(
   parameter int NUM_REQ = MUL_NUM_REQ,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    gidx
);

   int   idx;
   logic found;

   // First valid requester at (last+1), (last+2), ... modulo NUM_REQ wins.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last) + off) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gidx       = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// One pipelined signed multiplier time-shared among NUM_REQ requesters with tagged responses.
module myproject_mul_share_arb
   import myproject_mul_share_pkg::*;
#(
   parameter int NUM_REQ = MUL_NUM_REQ,
   parameter int A_WIDTH = MUL_A_WIDTH,
   parameter int B_WIDTH = MUL_B_WIDTH,
   parameter int P_WIDTH = MUL_P_WIDTH,
   parameter int LAT     = MUL_LAT,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [ID_W-1:0]              rsp_id,
   output logic signed [P_WIDTH-1:0]    rsp_p,
   output logic [15:0]                  issue_cnt
);

   localparam int FULL_W = A_WIDTH + B_WIDTH;

   // Full-precision signed product, wrapped to the low P_WIDTH bits.
   function automatic logic signed [P_WIDTH-1:0] wrap_mul(
      input logic signed [A_WIDTH-1:0] a,
      input logic signed [B_WIDTH-1:0] b
   );
      logic signed [FULL_W-1:0] full;
      full = a * b;
      return full[P_WIDTH-1:0];
   endfunction

   logic [NUM_REQ-1:0]        grant;
   logic [ID_W-1:0]           gidx;
   logic [ID_W-1:0]           last;
   logic                      hs;
   mul_stage_t                st_p1;
   logic signed [P_WIDTH-1:0] prod_p1;
   logic                      vld_out;
   logic [ID_W-1:0]           id_out;
   logic signed [P_WIDTH-1:0] p_out;

   myproject_mul_share_rr #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req_valid (req_valid),
      .last      (last),
      .grant     (grant),
      .gidx      (gidx)
   );

   // Grants are suppressed while reset is held so nothing handshakes during reset.
   assign req_ready = grant & {NUM_REQ{ap_rst_n}};
   assign hs        = |req_ready;

   // Priority pointer follows each handshake; starts so requester 0 is searched first.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         last <= ID_W'(NUM_REQ - 1);
      end else if (hs) begin
         last <= gidx;
      end
   end

   // Accepted-operation counter, sticks at all-ones.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         issue_cnt <= '0;
      end else if (hs && issue_cnt != 16'hFFFF) begin
         issue_cnt <= issue_cnt + 16'd1;
      end
   end

   // ---- stage 1: capture granted operands and owner tag ----
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         st_p1 <= '0;
      end else begin
         st_p1.valid <= hs;
         if (hs) begin
            st_p1.id <= gidx;
            st_p1.a  <= req_a[gidx*A_WIDTH +: A_WIDTH];
            st_p1.b  <= req_b[gidx*B_WIDTH +: B_WIDTH];
         end
      end
   end

   assign prod_p1 = wrap_mul(st_p1.a, st_p1.b);

   // ---- stages 2..LAT: product and tag ride along; data loads only with a valid op ----
   generate
      if (LAT == 1) begin : g_lat1
         assign vld_out = st_p1.valid;
         assign id_out  = st_p1.id;
         assign p_out   = prod_p1;
      end else begin : g_latn
         logic                      vld_p  [2:LAT];
         logic [ID_W-1:0]           id_p   [2:LAT];
         logic signed [P_WIDTH-1:0] prod_p [2:LAT];

         // Shift the tagged product down the pipeline; data holds when the slot is empty.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               for (int k = 2; k <= LAT; k++) begin
                  vld_p[k]  <= 1'b0;
                  id_p[k]   <= '0;
                  prod_p[k] <= '0;
               end
            end else begin
               vld_p[2] <= st_p1.valid;
               if (st_p1.valid) begin
                  id_p[2]   <= st_p1.id;
                  prod_p[2] <= prod_p1;
               end
               for (int k = 3; k <= LAT; k++) begin
                  vld_p[k] <= vld_p[k-1];
                  if (vld_p[k-1]) begin
                     id_p[k]   <= id_p[k-1];
                     prod_p[k] <= prod_p[k-1];
                  end
               end
            end
         end

         assign vld_out = vld_p[LAT];
         assign id_out  = id_p[LAT];
         assign p_out   = prod_p[LAT];
      end
   endgenerate

   // ---- output: one-hot pulse to the owner; tag and product hold between pulses ----
   assign rsp_valid = vld_out ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << id_out) : '0;
   assign rsp_id    = id_out;
   assign rsp_p     = p_out;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Directed bench for the shared-multiplier arbiter (NUM_REQ=4, LAT=2).
module tb_myproject_mul_share_arb;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [47:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  rsp_valid;
   logic [1:0]  rsp_id;
   logic [25:0] rsp_p;
   logic [15:0] issue_cnt;

   int checks = 0;
   int errors = 0;
   int sat_bad = 0;
   logic [31:0] prev_exp;
   logic [31:0] cur_exp;

   int fa [4] = '{1, 2, 3, 4};
   int fb [4] = '{-3, -4, -5, -6};
   int fp [4] = '{-3, -8, -15, -24};

   myproject_mul_share_arb dut (
      .ap_clk    (clk),
      .ap_rst_n  (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .issue_cnt (issue_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      req_a[i*12 +: 12] = a[11:0];
      req_b[i*16 +: 16] = b[15:0];
   endtask

   function automatic logic [31:0] w26(input int v);
      return {6'd0, v[25:0]};
   endfunction

   function automatic logic [31:0] mulx(input int a, input int b);
      logic signed [11:0] sa;
      logic signed [15:0] sb;
      logic signed [27:0] f;
      sa = a[11:0];
      sb = b[15:0];
      f  = sa * sb;
      return {6'd0, f[25:0]};
   endfunction

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      #1;
      // reset state, with all requesters asking
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_p", 32'(rsp_p), 32'h0);
      chk("rst_issue_cnt", 32'(issue_cnt), 32'h0);
      repeat (2) tick();
      req_valid = 4'h0;
      rst_n     = 1'b1;

      // single request from requester 2
      set_op(2, 100, -300);
      req_valid = 4'b0100;
      #1;
      chk("single_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'h0;
      chk("single_lat_early", 32'(rsp_valid), 32'h0);
      tick();
      chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("single_rsp_id", 32'(rsp_id), 32'd2);
      chk("single_rsp_p", 32'(rsp_p), w26(-30000));
      chk("single_issue_cnt", 32'(issue_cnt), 32'd1);
      tick();
      chk("single_pulse_end", 32'(rsp_valid), 32'h0);
      chk("single_p_hold", 32'(rsp_p), w26(-30000));

      // fairness from a fresh reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_op(i, fa[i], fb[i]);
      for (int c = 0; c < 7; c++) begin
         req_valid = (c < 5) ? 4'hF : 4'h0;
         #1;
         if (c < 5) chk("fair_ready", 32'(req_ready), 32'(1 << (c % 4)));
         tick();
         if (c >= 1 && c <= 5) begin
            chk("fair_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - 1) % 4)));
            chk("fair_rsp_p", 32'(rsp_p), w26(fp[(c - 1) % 4]));
         end else begin
            chk("fair_rsp_idle", 32'(rsp_valid), 32'h0);
         end
      end
      chk("fair_issue_cnt", 32'(issue_cnt), 32'd5);

      // wrap boundaries, back to back (last = 0)
      set_op(1, -2048, -32768);
      req_valid = 4'b0010;
      #1;
      chk("wrap_ready1", 32'(req_ready), 32'h2);
      tick();
      set_op(3, 2047, 32767);
      req_valid = 4'b1000;
      #1;
      chk("wrap_ready3", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'h0;
      chk("wrap_neg_valid", 32'(rsp_valid), 32'h2);
      chk("wrap_neg_p", 32'(rsp_p), 32'h0);
      tick();
      chk("wrap_pos_valid", 32'(rsp_valid), 32'h8);
      chk("wrap_pos_id", 32'(rsp_id), 32'd3);
      chk("wrap_pos_p", 32'(rsp_p), 32'd67074049);

      // pointer hold across idle cycles (last = 3)
      req_valid = 4'b0010;
      #1;
      chk("hold_grant1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'h0;
      #1;
      chk("hold_idle_ready", 32'(req_ready), 32'h0);
      repeat (3) tick();
      req_valid = 4'b0101;
      #1;
      chk("hold_first", 32'(req_ready), 32'h4);
      tick();
      chk("hold_next", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'h0;
      repeat (3) tick();

      // reset with operations in flight
      req_valid = 4'b0111;
      repeat (3) tick();
      req_valid = 4'h0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_issue_cnt", 32'(issue_cnt), 32'h0);
      chk("midrst_rsp_p", 32'(rsp_p), 32'h0);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("midrst_no_rsp", 32'(rsp_valid), 32'h0);
      end
      req_valid = 4'hF;
      #1;
      chk("midrst_last", 32'(req_ready), 32'h1);

      // saturation: 65,540 handshakes from requester 0, products checked throughout
      req_valid = 4'b0001;
      prev_exp  = '0;
      for (int n = 0; n < 65540; n++) begin
         set_op(0, n, -7 - (n % 5));
         cur_exp = mulx(n, -7 - (n % 5));
         tick();
         if (n >= 1) begin
            if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0 || {6'd0, rsp_p} !== prev_exp)
               sat_bad++;
         end
         prev_exp = cur_exp;
         if (n == 65533) chk("sat_before", 32'(issue_cnt), 32'hFFFE);
         if (n == 65534) chk("sat_reach", 32'(issue_cnt), 32'hFFFF);
      end
      req_valid = 4'h0;
      tick();
      if (rsp_valid !== 4'b0001 || {6'd0, rsp_p} !== prev_exp) sat_bad++;
      chk("sat_stay", 32'(issue_cnt), 32'hFFFF);
      chk("sat_rsp_bad", 32'(sat_bad), 32'd0);
      tick();
      chk("sat_drain", 32'(rsp_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
